// File: rtl/cr_clic_pkg.sv
// Shared FSM encoding and helpers for the CLIC interrupt arbiter.
package cr_clic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        HOLD = 2'b10
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // a beats b: higher priority wins, equal priority falls to the smaller key.
    function automatic logic cand_wins(
        input logic        a_vld,
        input logic [31:0] a_prio,
        input logic [31:0] a_key,
        input logic        b_vld,
        input logic [31:0] b_prio,
        input logic [31:0] b_key
    );
        return a_vld && (!b_vld || (a_prio > b_prio) ||
                         ((a_prio == b_prio) && (a_key < b_key)));
    endfunction

endpackage

// File: rtl/cr_clic_arb_grp.sv
// Combinational maximum finder over N (vld, prio, key) entries; returns the winning entry.
module cr_clic_arb_grp
    import cr_clic_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned PRIO_WIDTH = 6,
    parameter int unsigned ID_WIDTH   = 5
) (
    input  logic [N-1:0]            in_vld,
    input  logic [PRIO_WIDTH*N-1:0] in_prio,
    input  logic [ID_WIDTH*N-1:0]   in_id,
    input  logic [ID_WIDTH*N-1:0]   in_key,
    output logic                    out_vld,
    output logic [PRIO_WIDTH-1:0]   out_prio,
    output logic [ID_WIDTH-1:0]     out_id,
    output logic [ID_WIDTH-1:0]     out_key
);

    always_comb begin
        out_vld  = 1'b0;
        out_prio = '0;
        out_id   = '0;
        out_key  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand_wins(in_vld[i], 32'(in_prio[PRIO_WIDTH*i +: PRIO_WIDTH]),
                          32'(in_key[ID_WIDTH*i +: ID_WIDTH]),
                          out_vld, 32'(out_prio), 32'(out_key))) begin
                out_vld  = 1'b1;
                out_prio = in_prio[PRIO_WIDTH*i +: PRIO_WIDTH];
                out_id   = in_id[ID_WIDTH*i +: ID_WIDTH];
                out_key  = in_key[ID_WIDTH*i +: ID_WIDTH];
            end
        end
    end

endmodule

// File: rtl/cr_clic_arb_pipe.sv
// Two-stage (per-group, then global) CLIC interrupt arbiter with valid/ack hold.
// Define CR_CLIC_ARB_RR_EN for round-robin rotation among equal-priority sources.
module cr_clic_arb_pipe
    import cr_clic_pkg::*;
#(
    parameter int unsigned INT_NUM    = 32,
    parameter int unsigned PRIO_WIDTH = 6,
    parameter int unsigned GRP_NUM    = 4,
    parameter int unsigned ID_WIDTH   = clog2(INT_NUM)
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst,
    input  logic [INT_NUM-1:0]            int_pend_vec,
    input  logic [INT_NUM-1:0]            int_en_vec,
    input  logic [PRIO_WIDTH*INT_NUM-1:0] int_prio_vec,
    input  logic [PRIO_WIDTH-1:0]         int_thresh,
    input  logic                          arb_ack,
    input  logic                          arb_flush,
    output logic                          arb_vld,
    output logic [ID_WIDTH-1:0]           arb_id,
    output logic [PRIO_WIDTH-1:0]         arb_prio
);

    localparam int unsigned GRP_SIZE = INT_NUM / GRP_NUM;

    arb_state_e state_q, state_d;

    logic [INT_NUM-1:0]          elig;
    logic [ID_WIDTH*INT_NUM-1:0] src_id, src_key;

    logic [GRP_NUM-1:0]            s1_vld, grp_vld_q, live_vld;
    logic [PRIO_WIDTH*GRP_NUM-1:0] s1_prio, grp_prio_q;
    logic [ID_WIDTH*GRP_NUM-1:0]   s1_id, grp_id_q, s1_key, grp_key_q;

    logic                  s2_vld;
    logic [PRIO_WIDTH-1:0] s2_prio, arb_prio_q;
    logic [ID_WIDTH-1:0]   s2_id, s2_key, arb_id_q;
    logic                  unused_s2_key;

    logic grp_ld, grp_clr, arb_ld, last_ld;

`ifdef CR_CLIC_ARB_RR_EN
    logic [ID_WIDTH-1:0] last_id_q;
`endif

    always_comb begin
        for (int unsigned k = 0; k < INT_NUM; k++) begin
            elig[k] = int_pend_vec[k] & int_en_vec[k] &
                      (int_prio_vec[PRIO_WIDTH*k +: PRIO_WIDTH] > int_thresh);
            src_id[ID_WIDTH*k +: ID_WIDTH] = ID_WIDTH'(k);
        end
    end

`ifdef CR_CLIC_ARB_RR_EN
    // Key rotates so the source just after the last acknowledged one ranks first.
    always_comb begin
        int rr_off;
        rr_off = 0;
        for (int unsigned k = 0; k < INT_NUM; k++) begin
            rr_off = int'(k) - int'(last_id_q) - 1;
            if (rr_off < 0) rr_off = rr_off + int'(INT_NUM);
            src_key[ID_WIDTH*k +: ID_WIDTH] = ID_WIDTH'(rr_off);
        end
    end
`else
    assign src_key = src_id;
`endif

    for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp
        cr_clic_arb_grp #(
            .N          (GRP_SIZE),
            .PRIO_WIDTH (PRIO_WIDTH),
            .ID_WIDTH   (ID_WIDTH)
        ) u_grp (
            .in_vld   (elig[GRP_SIZE*g +: GRP_SIZE]),
            .in_prio  (int_prio_vec[PRIO_WIDTH*GRP_SIZE*g +: PRIO_WIDTH*GRP_SIZE]),
            .in_id    (src_id[ID_WIDTH*GRP_SIZE*g +: ID_WIDTH*GRP_SIZE]),
            .in_key   (src_key[ID_WIDTH*GRP_SIZE*g +: ID_WIDTH*GRP_SIZE]),
            .out_vld  (s1_vld[g]),
            .out_prio (s1_prio[PRIO_WIDTH*g +: PRIO_WIDTH]),
            .out_id   (s1_id[ID_WIDTH*g +: ID_WIDTH]),
            .out_key  (s1_key[ID_WIDTH*g +: ID_WIDTH])
        );
        // A group winner withdrawn since stage 1 no longer counts.
        assign live_vld[g] = grp_vld_q[g] & elig[grp_id_q[ID_WIDTH*g +: ID_WIDTH]];
    end

    cr_clic_arb_grp #(
        .N          (GRP_NUM),
        .PRIO_WIDTH (PRIO_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_glb (
        .in_vld   (live_vld),
        .in_prio  (grp_prio_q),
        .in_id    (grp_id_q),
        .in_key   (grp_key_q),
        .out_vld  (s2_vld),
        .out_prio (s2_prio),
        .out_id   (s2_id),
        .out_key  (s2_key)
    );

    assign unused_s2_key = ^s2_key;

    always_comb begin
        state_d = state_q;
        grp_ld  = 1'b0;
        grp_clr = 1'b0;
        arb_ld  = 1'b0;
        last_ld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    grp_ld  = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (arb_flush) begin
                    grp_clr = 1'b1;
                    state_d = IDLE;
                end else if (s2_vld) begin
                    arb_ld  = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (arb_ack) begin
                    last_ld = 1'b1;
                    state_d = IDLE;
                end else if (arb_flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q    <= IDLE;
            grp_vld_q  <= '0;
            grp_prio_q <= '0;
            grp_id_q   <= '0;
            grp_key_q  <= '0;
            arb_id_q   <= '0;
            arb_prio_q <= '0;
        end else begin
            state_q <= state_d;
            if (grp_ld) begin
                grp_vld_q  <= s1_vld;
                grp_prio_q <= s1_prio;
                grp_id_q   <= s1_id;
                grp_key_q  <= s1_key;
            end else if (grp_clr) begin
                grp_vld_q <= '0;
            end
            if (arb_ld) begin
                arb_id_q   <= s2_id;
                arb_prio_q <= s2_prio;
            end
        end
    end

`ifdef CR_CLIC_ARB_RR_EN
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            last_id_q <= ID_WIDTH'(INT_NUM - 1);
        end else if (last_ld) begin
            last_id_q <= arb_id_q;
        end
    end
`else
    logic unused_last_ld;
    assign unused_last_ld = last_ld;
`endif

    assign arb_vld  = (state_q == HOLD);
    assign arb_id   = arb_id_q;
    assign arb_prio = arb_prio_q;

endmodule
